prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 40 ++++
 rtl/prog_loader.sv | 171 +++++++++++++++++
 tb/tb_prog_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if -- stream-in / memory-out bundle for the program loader.
//
// Signals
//   in_valid    : stream word present (source -> loader)
//   in_data     : 32-bit stream word (source -> loader)
//   in_ready    : loader accepts the word this cycle (loader -> source)
//   restart     : one-cycle request for a new load from DONE/ERROR (source -> loader)
//   mem_wr_en   : instruction memory write strobe (loader -> memory)
//   mem_addr    : instruction memory byte address, AW bits (loader -> memory)
//   mem_wr_data : instruction word to write (loader -> memory)
//   cpu_reset   : holds the CPU in reset while high (loader -> CPU)
//   done        : program loaded, CPU released (loader -> system)
//   error       : load aborted, CPU stays held (loader -> system)
//
// Modports: master = stream source / system side, slave = the loader.

interface prog_loader_if #(
    parameter int AW = 32
) ();
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          restart;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic          cpu_reset;
    logic          done;
    logic          error;

    modport master (
        output in_valid, in_data, restart,
        input  in_ready, mem_wr_en, mem_addr, mem_wr_data, cpu_reset, done, error
    );

    modport slave (
        input  in_valid, in_data, restart,
        output in_ready, mem_wr_en, mem_addr, mem_wr_data, cpu_reset, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- loads a program from a valid/ready word stream into
// instruction memory and releases the CPU from reset when the load completes.
//
// Stream format: header word (N = bits [15:0]), then N program words, then
// (only when PROG_LOADER_CHECKSUM_EN is defined) one checksum word equal to
// the XOR of all program words.
//
// Ports
//   CLOCK : single clock, rising edge
//   RESET : synchronous, active-high reset
//   bus   : prog_loader_if.slave (stream in, memory write out, status out)
//
// Parameters
//   DEPTH : instruction memory size in words; largest legal N
//   AW    : width of mem_addr (byte address, word k written at 4*k)
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (adds CSUM state and
// XOR accumulator; a mismatching checksum aborts to ERROR).

module prog_loader #(
    parameter int DEPTH = 512,
    parameter int AW    = 32
) (
    input logic          CLOCK,
    input logic          RESET,
    prog_loader_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;
`endif

    state_t        state_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] nwords_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0]   acc_r;
`endif

    logic          xfer_s;
    logic [15:0]   hdr_n_s;
    logic          last_s;

    // in_ready depends on state only so the source never sees a loop through in_valid
`ifdef PROG_LOADER_CHECKSUM_EN
    assign bus.in_ready = (state_r == ST_IDLE) || (state_r == ST_LOAD) || (state_r == ST_CSUM);
`else
    assign bus.in_ready = (state_r == ST_IDLE) || (state_r == ST_LOAD);
`endif

    assign xfer_s  = bus.in_valid && bus.in_ready;
    assign hdr_n_s = bus.in_data[15:0];
    // count_r + 1 cannot overflow CW bits because count_r < nwords_r <= DEPTH
    assign last_s  = ((count_r + CW'(1'b1)) == nwords_r);

    // Loader FSM with registered memory strobe and status outputs
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r         <= ST_IDLE;
            count_r         <= '0;
            nwords_r        <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= 32'h0000_0000;
            bus.cpu_reset   <= 1'b1;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_r           <= 32'h0000_0000;
`endif
        end else begin
            // strobe is a single-cycle pulse following each accepted program word
            bus.mem_wr_en <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        count_r <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        acc_r   <= 32'h0000_0000;
`endif
                        if (hdr_n_s > 16'(DEPTH)) begin
                            state_r   <= ST_ERROR;
                            bus.error <= 1'b1;
                        end else if (hdr_n_s == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_r       <= ST_CSUM;
`else
                            state_r       <= ST_DONE;
                            bus.done      <= 1'b1;
                            bus.cpu_reset <= 1'b0;
`endif
                        end else begin
                            state_r  <= ST_LOAD;
                            nwords_r <= CW'(hdr_n_s);
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        bus.mem_wr_en   <= 1'b1;
                        bus.mem_addr    <= AW'({count_r, 2'b00});
                        bus.mem_wr_data <= bus.in_data;
                        count_r         <= count_r + CW'(1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        acc_r           <= acc_r ^ bus.in_data;
                        if (last_s) begin
                            state_r <= ST_CSUM;
                        end
`else
                        // done rises together with the final write strobe
                        if (last_s) begin
                            state_r       <= ST_DONE;
                            bus.done      <= 1'b1;
                            bus.cpu_reset <= 1'b0;
                        end
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer_s) begin
                        if (bus.in_data == acc_r) begin
                            state_r       <= ST_DONE;
                            bus.done      <= 1'b1;
                            bus.cpu_reset <= 1'b0;
                        end else begin
                            state_r   <= ST_ERROR;
                            bus.error <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE, ST_ERROR: begin
                    if (bus.restart) begin
                        state_r       <= ST_IDLE;
                        count_r       <= '0;
                        bus.cpu_reset <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.error     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        acc_r         <= 32'h0000_0000;
`endif
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    count_r       <= '0;
                    bus.cpu_reset <= 1'b1;
                    bus.done      <= 1'b0;
                    bus.error     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- table-driven self-checking bench for prog_loader.
// Expected memory writes are queued when program words are driven and
// compared by a monitor when the loader strobes mem_wr_en.

module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic CLOCK = 1'b0;
    logic RESET;

    prog_loader_if #(.AW(32)) bus ();

    prog_loader #(.DEPTH(512), .AW(32)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0]      hdr;
        logic [3:0][31:0] w;     // w[0] is the first program word
        int               gap;   // idle cycles inserted before program word 1
        bit               err;   // load expected to end in ERROR
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_done;
    } wr_t;

    vec_t tbl[8];
    wr_t  exp_q[$];
    wr_t  mon_e;
    int   vec_cnt = 0;
    int   miss_cnt = 0;
    int   wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Words beyond the four stored in a vector come from a fixed pattern
    function automatic logic [31:0] wval(input logic [3:0][31:0] w, input int k);
        logic [31:0] r;
        if (k < 4) r = w[k];
        else       r = {16'hC0DE, 16'(k)};
        return r;
    endfunction

    // Drive one word and wait (bounded) until it transfers; in_valid stays high
    task automatic send(input logic [31:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 20) begin
            @(posedge CLOCK); #1;
            n++;
        end
        if (!bus.in_ready) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for word %0h", d);
        end else begin
            @(posedge CLOCK); #1;
        end
    endtask

    task automatic send_prog(input logic [31:0] d, input int k, input bit last);
        wr_t e;
        e.addr = 32'(4 * k);
        e.data = d;
        e.chk_done = last && !CSUM_EN;
        exp_q.push_back(e);
        send(d);
    endtask

    task automatic pulse_restart();
        bus.in_valid = 1'b0;
        bus.restart  = 1'b1;
        @(posedge CLOCK); #1;
        bus.restart  = 1'b0;
        @(negedge CLOCK);
        check("rs_in_ready", 32'(bus.in_ready), 32'd1);
        check("rs_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("rs_done", 32'(bus.done), 32'd0);
        check("rs_error", 32'(bus.error), 32'd0);
    endtask

    // Write monitor: every strobe must match the head of the expected queue
    always @(negedge CLOCK) begin
        if (bus.mem_wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.mem_addr, bus.mem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, mon_e.addr);
                check("wr_data", bus.mem_wr_data, mon_e.data);
                if (mon_e.chk_done) begin
                    check("done_with_last", 32'(bus.done), 32'd1);
                    check("cpu_rst_with_last", 32'(bus.cpu_reset), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] csum;
        logic [31:0] w;
        int n;

        tbl[0] = '{hdr: 32'd3,          w: {32'h0, 32'hC, 32'hB, 32'hA},    gap: 0, err: 1'b0};
        tbl[1] = '{hdr: 32'd2,          w: {32'h0, 32'h0, 32'h22, 32'h11},  gap: 3, err: 1'b0};
        tbl[2] = '{hdr: 32'd513,        w: {32'h0, 32'h0, 32'h0, 32'h0},    gap: 0, err: 1'b1};
        tbl[3] = '{hdr: 32'd0,          w: {32'h0, 32'h0, 32'h0, 32'h0},    gap: 0, err: 1'b0};
        tbl[4] = '{hdr: 32'hFFFF_0001,  w: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, gap: 0, err: 1'b0};
        tbl[5] = '{hdr: 32'd512,        w: {32'h4, 32'h3, 32'h2, 32'h1},    gap: 0, err: 1'b0};
        tbl[6] = '{hdr: 32'h0000_FFFF,  w: {32'h0, 32'h0, 32'h0, 32'h0},    gap: 0, err: 1'b1};
        tbl[7] = '{hdr: 32'd3,          w: {32'h0, 32'h3, 32'h2, 32'h1},    gap: 1, err: 1'b0};

        RESET = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.restart  = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1 RESET = 1'b0;
        @(negedge CLOCK);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wr_data, 32'd0);

        for (int i = 0; i < 8; i++) begin
            wr_cnt = 0;
            csum = 32'h0;
            n = int'(tbl[i].hdr[15:0]);
            send(tbl[i].hdr);
            if (!tbl[i].err) begin
                for (int k = 0; k < n; k++) begin
                    w = wval(tbl[i].w, k);
                    csum = csum ^ w;
                    if (k == 1 && tbl[i].gap > 0) begin
                        bus.in_valid = 1'b0;
                        repeat (tbl[i].gap) begin
                            @(posedge CLOCK); #1;
                        end
                    end
                    send_prog(w, k, k == n - 1);
                end
                if (CSUM_EN) send(csum);
            end
            bus.in_valid = 1'b0;
            @(negedge CLOCK);
            check("end_done", 32'(bus.done), 32'(!tbl[i].err));
            check("end_error", 32'(bus.error), 32'(tbl[i].err));
            check("end_cpu_reset", 32'(bus.cpu_reset), 32'(tbl[i].err));
            check("end_in_ready", 32'(bus.in_ready), 32'd0);
            repeat (2) @(negedge CLOCK);
            check("end_wr_count", 32'(wr_cnt), tbl[i].err ? 32'd0 : 32'(n));
            check("end_queue_empty", 32'(exp_q.size()), 32'd0);
            pulse_restart();
        end

        // RESET mid-load: the word accepted in the reset cycle must not be written
        wr_cnt = 0;
        send(32'd4);
        send_prog(32'h1, 0, 1'b0);
        send_prog(32'h2, 1, 1'b0);
        bus.in_data = 32'h3;
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge CLOCK);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("mid_rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("mid_rst_addr", bus.mem_addr, 32'd0);
        send(32'd1);
        send_prog(32'h55, 0, 1'b1);
        if (CSUM_EN) send(32'h55);
        bus.in_valid = 1'b0;
        @(negedge CLOCK);
        check("reload_done", 32'(bus.done), 32'd1);
        repeat (2) @(negedge CLOCK);
        check("reload_wr_count", 32'(wr_cnt), 32'd3);
        pulse_restart();

        // restart during LOAD is ignored
        wr_cnt = 0;
        send(32'd2);
        send_prog(32'h77, 0, 1'b0);
        bus.in_valid = 1'b0;
        bus.restart  = 1'b1;
        @(posedge CLOCK); #1;
        bus.restart  = 1'b0;
        @(negedge CLOCK);
        check("ld_restart_in_ready", 32'(bus.in_ready), 32'd1);
        check("ld_restart_done", 32'(bus.done), 32'd0);
        send_prog(32'h88, 1, 1'b1);
        if (CSUM_EN) send(32'h77 ^ 32'h88);
        bus.in_valid = 1'b0;
        @(negedge CLOCK);
        check("ld_restart_end_done", 32'(bus.done), 32'd1);
        repeat (2) @(negedge CLOCK);
        check("ld_restart_wr_count", 32'(wr_cnt), 32'd2);
        pulse_restart();

`ifdef PROG_LOADER_CHECKSUM_EN
        // wrong checksum aborts the load
        send(32'd3);
        send_prog(32'h1, 0, 1'b0);
        send_prog(32'h2, 1, 1'b0);
        send_prog(32'h3, 2, 1'b0);
        send(32'h1);
        bus.in_valid = 1'b0;
        @(negedge CLOCK);
        check("bad_csum_error", 32'(bus.error), 32'd1);
        check("bad_csum_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("bad_csum_done", 32'(bus.done), 32'd0);
        pulse_restart();
`endif

        // RESET wins over a simultaneous restart while in DONE
        send(32'd0);
        if (CSUM_EN) send(32'h0);
        bus.in_valid = 1'b0;
        @(negedge CLOCK);
        check("zero_hdr_done", 32'(bus.done), 32'd1);
        RESET = 1'b1;
        bus.restart = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'd5;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        bus.restart = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge CLOCK);
        check("prio_in_ready", 32'(bus.in_ready), 32'd1);
        check("prio_done", 32'(bus.done), 32'd0);
        check("prio_cpu_reset", 32'(bus.cpu_reset), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
